img_row_ring_wr: RTL and testbench

// Upstream feeder of the HDMI 1080P scaler read stage. Accepts the 640x480 camera RGB pixel stream,

---
 rtl/img_row_ring_wr_pkg.sv | 19 +
 rtl/img_row_ring_wr_row_ring_occ.sv | 59 +++++
 rtl/img_row_ring_wr.sv | 138 +++++++++++++
 tb/tb_img_row_ring_wr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/img_row_ring_wr_pkg.sv
// Shared constants for the camera row-ring writer: frame geometry, FSM encoding
// and the BRAM address packing used by both ring channels.
package img_row_ring_wr_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int RING_ROWS = 8;

  // One-hot write FSM encoding; the spare fourth bit keeps the legacy 4-bit width.
  localparam logic [3:0] ST_IDLE      = 4'b0001;
  localparam logic [3:0] ST_ROW_WR    = 4'b0010;
  localparam logic [3:0] ST_RING_FULL = 4'b0100;

  // Each channel holds four ring rows; slot[0] picks the channel, slot[2:1] the row inside it.
  function automatic logic [11:0] pack_addr(input logic [1:0] slot_sel, input logic [9:0] col);
    return {slot_sel, col};
  endfunction

endpackage

// File: rtl/img_row_ring_wr_row_ring_occ.sv
// Ring occupancy and descriptor queue: tracks completed-but-unreleased rows, the
// read pointer / head row number, and how many descriptors the consumer may see.
module row_ring_occ
  import img_row_ring_wr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       row_done,
  input  logic       frame_last,
  input  logic       pop_req,
  output logic       pop_ok,
  output logic       full_next,
  output logic       empty,
  output logic [2:0] rd_slot,
  output logic [8:0] head_row
);

  logic [3:0] occ;
  logic [3:0] occ_next;
  logic [3:0] visible;
  logic       frame_done;

  // A row is only published once its successor exists, except the last row of a frame.
  always_comb begin
    visible   = frame_done ? occ : ((occ != 4'd0) ? occ - 4'd1 : 4'd0);
    empty     = (visible == 4'd0);
    pop_ok    = pop_req & ~empty;
    occ_next  = occ;
    if (row_done & ~pop_ok)
      occ_next = occ + 4'd1;
    else if (~row_done & pop_ok)
      occ_next = occ - 4'd1;
    full_next = (occ_next == 4'(RING_ROWS));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ        <= 4'd0;
      rd_slot    <= 3'd0;
      head_row   <= 9'd0;
      frame_done <= 1'b0;
    end else if (flush) begin
      occ        <= {3'b000, row_done};
      rd_slot    <= 3'd0;
      head_row   <= 9'd0;
      frame_done <= frame_last;
    end else begin
      occ <= occ_next;
      if (pop_ok) begin
        rd_slot  <= rd_slot + 3'd1;
        head_row <= head_row + 9'd1;
      end
      if (frame_last)
        frame_done <= 1'b1;
    end
  end

endmodule

// File: rtl/img_row_ring_wr.sv
// Camera-to-BRAM row ring writer: places each image row into an 8-slot ring split
// over two channels and back-pressures the camera while every slot is still held.
module img_row_ring_wr
  import img_row_ring_wr_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic        clk,
  input  logic        frst,
  input  logic [23:0] i_pix_rgb,
  input  logic        i_pix_vld,
  input  logic        i_pix_sof,
  output logic        o_pix_rdy,
  output logic [11:0] o_ch0_waddr,
  output logic [31:0] o_ch0_wdata,
  output logic        o_ch0_we,
  output logic [11:0] o_ch1_waddr,
  output logic [31:0] o_ch1_wdata,
  output logic        o_ch1_we,
  output logic [2:0]  o_8row_id,
  output logic [8:0]  o_8row_h,
  output logic        o_8row_empty,
  input  logic        i_8row_re,
  output logic        o_frame_err
);

  logic [3:0] state;
  logic [3:0] state_next;
  logic [9:0] col;
  logic [8:0] row;
  logic [2:0] wr_slot;
  logic       accept;
  logic       sof_acc;
  logic       wr_en;
  logic [2:0] w_slot;
  logic [9:0] w_col;
  logic [8:0] w_row;
  logic       row_done;
  logic       frame_last;
  logic       pop_ok;
  logic       full_next;

  // An accepted SOF always restarts the frame at slot 0 / row 0 / col 0.
  always_comb begin
    accept     = i_pix_vld & o_pix_rdy;
    sof_acc    = accept & i_pix_sof;
    wr_en      = sof_acc | (accept & (state == ST_ROW_WR));
    w_slot     = sof_acc ? 3'd0  : wr_slot;
    w_col      = sof_acc ? 10'd0 : col;
    w_row      = sof_acc ? 9'd0  : row;
    row_done   = wr_en & (w_col == 10'(IMG_W - 1));
    frame_last = row_done & (w_row == 9'(IMG_H - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (sof_acc) state_next = ST_ROW_WR;
      ST_ROW_WR:    state_next = ST_ROW_WR;
      ST_RING_FULL: if (pop_ok) state_next = ST_ROW_WR;
      default:      state_next = ST_IDLE;
    endcase
    if (row_done) begin
      if (frame_last)
        state_next = ST_IDLE;
      else if (full_next)
        state_next = ST_RING_FULL;
      else
        state_next = ST_ROW_WR;
    end
  end

  // Ready is registered from the next state so it stays low while reset is held.
  always_ff @(posedge clk or posedge frst) begin
    if (frst) begin
      state       <= ST_IDLE;
      o_pix_rdy   <= 1'b0;
      o_frame_err <= 1'b0;
      col         <= 10'd0;
      row         <= 9'd0;
      wr_slot     <= 3'd0;
    end else begin
      state     <= state_next;
      o_pix_rdy <= (state_next != ST_RING_FULL);
      if (sof_acc && (state != ST_IDLE))
        o_frame_err <= 1'b1;
      if (wr_en) begin
        if (w_col == 10'(IMG_W - 1)) begin
          col     <= 10'd0;
          row     <= w_row + 9'd1;
          wr_slot <= w_slot + 3'd1;
        end else begin
          col     <= w_col + 10'd1;
          row     <= w_row;
          wr_slot <= w_slot;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge frst) begin
    if (frst) begin
      o_ch0_we    <= 1'b0;
      o_ch1_we    <= 1'b0;
      o_ch0_waddr <= 12'd0;
      o_ch1_waddr <= 12'd0;
      o_ch0_wdata <= 32'd0;
      o_ch1_wdata <= 32'd0;
    end else begin
      o_ch0_we <= wr_en & ~w_slot[0];
      o_ch1_we <= wr_en & w_slot[0];
      if (wr_en & ~w_slot[0]) begin
        o_ch0_waddr <= pack_addr(w_slot[2:1], w_col);
        o_ch0_wdata <= {8'h00, i_pix_rgb};
      end
      if (wr_en & w_slot[0]) begin
        o_ch1_waddr <= pack_addr(w_slot[2:1], w_col);
        o_ch1_wdata <= {8'h00, i_pix_rgb};
      end
    end
  end

  row_ring_occ u_occ (
    .clk        (clk),
    .rst        (frst),
    .flush      (sof_acc),
    .row_done   (row_done),
    .frame_last (frame_last),
    .pop_req    (i_8row_re),
    .pop_ok     (pop_ok),
    .full_next  (full_next),
    .empty      (o_8row_empty),
    .rd_slot    (o_8row_id),
    .head_row   (o_8row_h)
  );

endmodule

// File: tb/tb_img_row_ring_wr.sv
// Self-checking bench for img_row_ring_wr: a reduced 32x24 frame, with every BRAM
// write matched against a scoreboard filled as pixels are handed to the writer.
module tb_img_row_ring_wr;

  localparam int W = 32;
  localparam int H = 24;

  logic        clk;
  logic        frst;
  logic [23:0] i_pix_rgb;
  logic        i_pix_vld;
  logic        i_pix_sof;
  logic        o_pix_rdy;
  logic [11:0] o_ch0_waddr;
  logic [31:0] o_ch0_wdata;
  logic        o_ch0_we;
  logic [11:0] o_ch1_waddr;
  logic [31:0] o_ch1_wdata;
  logic        o_ch1_we;
  logic [2:0]  o_8row_id;
  logic [8:0]  o_8row_h;
  logic        o_8row_empty;
  logic        i_8row_re;
  logic        o_frame_err;

  int checkCount = 0;
  int errorCount = 0;
  logic [44:0] sbQ[$];

  img_row_ring_wr #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .frst         (frst),
    .i_pix_rgb    (i_pix_rgb),
    .i_pix_vld    (i_pix_vld),
    .i_pix_sof    (i_pix_sof),
    .o_pix_rdy    (o_pix_rdy),
    .o_ch0_waddr  (o_ch0_waddr),
    .o_ch0_wdata  (o_ch0_wdata),
    .o_ch0_we     (o_ch0_we),
    .o_ch1_waddr  (o_ch1_waddr),
    .o_ch1_wdata  (o_ch1_wdata),
    .o_ch1_we     (o_ch1_we),
    .o_8row_id    (o_8row_id),
    .o_8row_h     (o_8row_h),
    .o_8row_empty (o_8row_empty),
    .i_8row_re    (i_8row_re),
    .o_frame_err  (o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every write strobe must match the oldest outstanding pixel: channel, address and data.
  always @(negedge clk) begin
    if (!frst && (o_ch0_we || o_ch1_we)) begin
      checkOutput("single_we", {63'd0, o_ch0_we & o_ch1_we}, 64'd0);
      checkOutput("wr_pending", {63'd0, sbQ.size() != 0}, 64'd1);
      if (sbQ.size() != 0) begin
        logic [44:0] expWr;
        logic [44:0] obsWr;
        expWr = sbQ.pop_front();
        obsWr = o_ch1_we ? {1'b1, o_ch1_waddr, o_ch1_wdata} : {1'b0, o_ch0_waddr, o_ch0_wdata};
        checkOutput("bram_write", {19'd0, obsWr}, {19'd0, expWr});
      end
    end
  end

  // Offer one pixel from a falling edge; it transfers on the first rising edge with ready high.
  task automatic applyStimulus(input int r, input int c, input bit sof, input bit autoPop,
                               input bit forcePop, input bit expectWrite);
    int waitCnt;
    logic [23:0] rgb;
    logic [8:0] rowBits;
    waitCnt   = 0;
    rgb       = 24'($urandom);
    rowBits   = 9'(r);
    i_pix_rgb = rgb;
    i_pix_sof = sof;
    i_pix_vld = 1'b1;
    while (!o_pix_rdy && waitCnt < 50) begin
      @(posedge clk);
      @(negedge clk);
      waitCnt++;
    end
    if (!o_pix_rdy) begin
      checkOutput("rdy_timeout", {63'd0, o_pix_rdy}, 64'd1);
      i_pix_vld = 1'b0;
      i_pix_sof = 1'b0;
      return;
    end
    i_8row_re = forcePop | (autoPop & ~o_8row_empty);
    if (expectWrite)
      sbQ.push_back({rowBits[0], rowBits[2:1], 10'(c), 8'h00, rgb});
    @(posedge clk);
    @(negedge clk);
    i_pix_vld = 1'b0;
    i_pix_sof = 1'b0;
    i_8row_re = 1'b0;
  endtask

  task automatic sendRow(input int r, input bit sof, input bit autoPop, input bit lastPop);
    for (int c = 0; c < W; c++)
      applyStimulus(r, c, sof && (c == 0), autoPop, lastPop && (c == W - 1), 1'b1);
  endtask

  task automatic popPulse();
    i_8row_re = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_8row_re = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    frst      = 1'b1;
    i_pix_vld = 1'b0;
    i_pix_sof = 1'b0;
    i_8row_re = 1'b0;
    i_pix_rgb = 24'd0;
    @(negedge clk);
    checkOutput("rst_rdy", {63'd0, o_pix_rdy}, 64'd0);
    checkOutput("rst_we", {62'd0, o_ch0_we, o_ch1_we}, 64'd0);
    checkOutput("rst_addr", {40'd0, o_ch0_waddr, o_ch1_waddr}, 64'd0);
    checkOutput("rst_empty", {63'd0, o_8row_empty}, 64'd1);
    checkOutput("rst_head", {52'd0, o_8row_id, o_8row_h}, 64'd0);
    checkOutput("rst_err", {63'd0, o_frame_err}, 64'd0);
    sbQ.delete();
    frst = 1'b0;
    @(negedge clk);
    checkOutput("rdy_after_rst", {63'd0, o_pix_rdy}, 64'd1);
  endtask

  initial begin
    frst = 1'b1;
    i_pix_vld = 1'b0;
    i_pix_sof = 1'b0;
    i_8row_re = 1'b0;
    i_pix_rgb = 24'd0;
    doReset();

    // Idle: non-SOF pixels are swallowed and a pop on an empty queue does nothing.
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    popPulse();
    checkOutput("idle_empty", {63'd0, o_8row_empty}, 64'd1);
    checkOutput("idle_head", {52'd0, o_8row_id, o_8row_h}, 64'd0);

    // Rows 0 and 1: row 0 is only published once row 1 is complete.
    sendRow(0, 1'b1, 1'b0, 1'b0);
    checkOutput("row0_hidden", {63'd0, o_8row_empty}, 64'd1);
    sendRow(1, 1'b0, 1'b0, 1'b0);
    checkOutput("row1_visible", {63'd0, o_8row_empty}, 64'd0);
    checkOutput("row1_head", {52'd0, o_8row_id, o_8row_h}, 64'd0);

    // Fill the ring; after row 7 every slot is held and the camera is stalled.
    for (int r = 2; r < 8; r++)
      sendRow(r, 1'b0, 1'b0, 1'b0);
    checkOutput("full_rdy", {63'd0, o_pix_rdy}, 64'd0);
    checkOutput("full_head", {52'd0, o_8row_id, o_8row_h}, 64'd0);
    popPulse();
    checkOutput("release_rdy", {63'd0, o_pix_rdy}, 64'd1);
    checkOutput("release_head", {52'd0, o_8row_id, o_8row_h}, {52'd0, 3'd1, 9'd1});

    // Row 8 lands in slot 0; its last pixel coincides with a pop so occupancy holds.
    sendRow(8, 1'b0, 1'b0, 1'b1);
    checkOutput("coincide_rdy", {63'd0, o_pix_rdy}, 64'd1);
    checkOutput("coincide_head", {52'd0, o_8row_id, o_8row_h}, {52'd0, 3'd2, 9'd2});
    sendRow(9, 1'b0, 1'b0, 1'b0);
    checkOutput("refull_rdy", {63'd0, o_pix_rdy}, 64'd0);

    // Whole frame with an eager consumer; the final row must end up visible.
    doReset();
    for (int r = 0; r < H; r++)
      sendRow(r, r == 0, 1'b1, 1'b0);
    checkOutput("frame_idle_rdy", {63'd0, o_pix_rdy}, 64'd1);
    checkOutput("frame_tail_vis", {63'd0, o_8row_empty}, 64'd0);
    checkOutput("frame_no_err", {63'd0, o_frame_err}, 64'd0);
    for (int n = 0; n < 16 && o_8row_h != 9'(H - 1) && !o_8row_empty; n++)
      popPulse();
    checkOutput("last_row_head", {52'd0, o_8row_id, o_8row_h}, {52'd0, 3'((H - 1) % 8), 9'(H - 1)});
    checkOutput("last_row_vis", {63'd0, o_8row_empty}, 64'd0);
    popPulse();
    checkOutput("drained_empty", {63'd0, o_8row_empty}, 64'd1);

    // A new frame interrupted by SOF at row 10, col 5.
    for (int r = 0; r < 10; r++)
      sendRow(r, r == 0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++)
      applyStimulus(10, c, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("pre_sof_err", {63'd0, o_frame_err}, 64'd0);
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("sof_err", {63'd0, o_frame_err}, 64'd1);
    checkOutput("sof_flush_empty", {63'd0, o_8row_empty}, 64'd1);
    checkOutput("sof_flush_head", {52'd0, o_8row_id, o_8row_h}, 64'd0);
    checkOutput("sof_rdy", {63'd0, o_pix_rdy}, 64'd1);
    for (int c = 1; c < W; c++)
      applyStimulus(0, c, 1'b0, 1'b0, 1'b0, 1'b1);
    sendRow(1, 1'b0, 1'b0, 1'b0);
    checkOutput("restart_vis", {63'd0, o_8row_empty}, 64'd0);

    @(negedge clk);
    @(negedge clk);
    checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
